// File: rtl/npc_pkg.sv
// rtl/npc_pkg.sv - shared NPC core encodings, FSM states and reset PC default
package npc_pkg;

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_IMM    = 2'b01;
    localparam logic [1:0] PC_ALU    = 2'b10;
    localparam logic [1:0] PC_BRANCH = 2'b11;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_EXEC  = 2'b10,
        ST_HALT  = 2'b11
    } pc_state_t;

endpackage

// File: rtl/pc_next_calc.sv
// rtl/pc_next_calc.sv - combinational next-PC selection and alignment check
module pc_next_calc
    import npc_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc,
    input  logic [1:0]      PC_src,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] alu_result,
    input  logic            branch_taken,
    output logic [XLEN-1:0] next_pc,
    output logic            misaligned
);

    logic [XLEN-1:0] seq_target;
    logic [XLEN-1:0] rel_target;
    logic [XLEN-1:0] alu_target;

    // JALR clears bit 0 of the ALU sum; bit 1 may still be set and is caught below
    assign seq_target = pc + XLEN'(4);
    assign rel_target = pc + imm;
    assign alu_target = alu_result & ~XLEN'(1);

    // Select the target; a not-taken branch falls through to pc+4
    always_comb begin
        next_pc = seq_target;
        case (PC_src)
            PC_PLUS4:  next_pc = seq_target;
            PC_IMM:    next_pc = rel_target;
            PC_ALU:    next_pc = alu_target;
            PC_BRANCH: next_pc = branch_taken ? rel_target : seq_target;
            default:   next_pc = seq_target;
        endcase
    end

    assign misaligned = |next_pc[1:0];

endmodule

// File: rtl/pc_update.sv
// rtl/pc_update.sv - architectural PC register, fetch handshake FSM and retire counter
module pc_update
    import npc_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      PC_src,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] alu_result,
    input  logic            branch_taken,
    input  logic            commit_valid,
    output logic            ifu_req_valid,
    input  logic            ifu_req_ready,
    output logic [XLEN-1:0] ifu_req_addr,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic [63:0]     instret,
    output logic            misalign_err,
    output logic            halted
);

    pc_state_t       state;
    pc_state_t       state_next;
    logic [XLEN-1:0] next_pc;
    logic            target_misaligned;
    logic            do_retire;
    logic            do_trap;

    pc_next_calc #(.XLEN(XLEN)) u_next (
        .pc           (pc),
        .PC_src       (PC_src),
        .imm          (imm),
        .alu_result   (alu_result),
        .branch_taken (branch_taken),
        .next_pc      (next_pc),
        .misaligned   (target_misaligned)
    );

    // State register, PC, retire counter and sticky error; reset aborts any pending fetch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            pc           <= RESET_PC;
            instret      <= 64'd0;
            misalign_err <= 1'b0;
        end else begin
            state <= state_next;
            if (do_retire) begin
                pc      <= next_pc;
                instret <= instret + 64'd1;
            end
            if (do_trap) begin
                misalign_err <= 1'b1;
            end
        end
    end

    // Next-state and commit decisions; decoder inputs only matter in EXEC with commit
    always_comb begin
        state_next = state;
        do_retire  = 1'b0;
        do_trap    = 1'b0;
        case (state)
            ST_IDLE:  state_next = ST_FETCH;
            ST_FETCH: if (ifu_req_ready) state_next = ST_EXEC;
            ST_EXEC: begin
                if (commit_valid) begin
                    if (target_misaligned) begin
                        do_trap    = 1'b1;
                        state_next = ST_HALT;
                    end else begin
                        do_retire  = 1'b1;
                        state_next = ST_FETCH;
                    end
                end
            end
            ST_HALT:  state_next = ST_HALT;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Request outputs decode straight from the state flops, never from ready
    assign ifu_req_valid = (state == ST_FETCH);
    assign ifu_req_addr  = pc;
    assign halted        = (state == ST_HALT);
    assign pc_plus4      = pc + XLEN'(4);

endmodule
